// File: rtl/sub_divider_ctrl.sv
// Multi-cycle restoring divider sequencer. One WIDTH+1 bit subtractor is
// reused once per RUN cycle; results and flags are registered and held
// until the next completed operation.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one restoring step per edge, cnt counts down to 0
// DONE  | one-cycle done pulse, then back to IDLE unconditionally

module sub_divider_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff
);

    // Plain subtractor; the MSB of diff doubles as the borrow indication.
    assign diff = a - b;

endmodule

module sub_divider_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [3:0]       flags
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // The partial remainder is always below the divisor, so its top bit
    // (bit WIDTH of the nominal WIDTH+1 bit register) is never set and is
    // not stored. The full WIDTH+1 bit width lives in s/diff.
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   s;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    assign s = {r, q[WIDTH-1]};

    sub_divider_sub #(.W(WIDTH + 1)) u_sub (
        .a    (s),
        .b    ({1'b0, d}),
        .diff (diff)
    );

    // Restoring step: keep the difference when it did not borrow.
    always_comb begin
        r_step = s[WIDTH-1:0];
        q_step = {q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            r_step = diff[WIDTH-1:0];
            q_step = {q[WIDTH-2:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (divisor != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            flags     <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (divisor != '0)) begin
                        d   <= divisor;
                        q   <= dividend;
                        r   <= '0;
                        cnt <= CW'(WIDTH - 1);
                    end else if (start) begin
                        // Divide-by-zero completes immediately with V set.
                        quotient  <= '1;
                        remainder <= dividend;
                        flags     <= 4'b0001;
                    end
                end
                S_RUN: begin
                    r <= r_step;
                    q <= q_step;
                    if (cnt == '0) begin
                        quotient  <= q_step;
                        remainder <= r_step;
                        flags     <= {1'b0, (q_step == '0), 2'b00};
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_divider_ctrl.sv
// Bench for sub_divider_ctrl: a WIDTH=8 and a WIDTH=4 instance, directed
// cases followed by random operands, checked against integer / and %.

module tb_sub_divider_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8;
    logic [7:0] q8, r8;
    logic [3:0] f8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4;
    logic [3:0] q4, r4;
    logic [3:0] f4;

    int n_cmp = 0;
    int n_err = 0;

    sub_divider_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .dividend  (a8),
        .divisor   (b8),
        .busy      (busy8),
        .done      (done8),
        .quotient  (q8),
        .remainder (r8),
        .flags     (f8)
    );

    sub_divider_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .dividend  (a4),
        .divisor   (b4),
        .busy      (busy4),
        .done      (done4),
        .quotient  (q4),
        .remainder (r4),
        .flags     (f4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction
    function automatic logic [7:0] get_q(input int w);
        return (w == 4) ? {4'b0, q4} : q8;
    endfunction
    function automatic logic [7:0] get_r(input int w);
        return (w == 4) ? {4'b0, r4} : r8;
    endfunction
    function automatic logic [3:0] get_f(input int w);
        return (w == 4) ? f4 : f8;
    endfunction

    task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (w == 4) begin
            start4 = s;
            a4     = a[3:0];
            b4     = b[3:0];
        end else begin
            start8 = s;
            a8     = a;
            b8     = b;
        end
    endtask

    // One full operation from an IDLE cycle: start pulse, then follow it to done.
    task automatic run_div(input int w, input logic [7:0] a_in, input logic [7:0] b_in, input string tag);
        logic [7:0] mask, a, b, eq, er, pq, pr;
        logic [3:0] ef, pf;
        int  lat, nb, exp_lat;
        bit  seen, stable, both;
        mask = (w == 4) ? 8'h0F : 8'hFF;
        a = a_in & mask;
        b = b_in & mask;
        if (b == 8'd0) begin
            eq = mask;
            er = a;
            ef = 4'b0001;
            exp_lat = 0;
        end else begin
            eq = a / b;
            er = a % b;
            ef = {1'b0, (eq == 8'd0), 2'b00};
            exp_lat = w;
        end
        pq = get_q(w);
        pr = get_r(w);
        pf = get_f(w);
        drive(w, 1'b1, a, b);
        step();
        drive(w, 1'b0, 8'($urandom), 8'($urandom));
        lat = 0; nb = 0; seen = 0; stable = 1; both = 0;
        for (int i = 0; i < 40; i++) begin
            if (get_busy(w) && get_done(w)) both = 1;
            if (get_done(w)) begin
                seen = 1;
                break;
            end
            if (get_busy(w)) nb++;
            if (get_q(w) !== pq || get_r(w) !== pr || get_f(w) !== pf) stable = 0;
            step();
            lat++;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busycycles"}, 32'(nb), 32'(exp_lat));
        check({tag, "_busy_and_done"}, 32'(both), 32'd0);
        check({tag, "_hold"}, 32'(stable), 32'd1);
        check({tag, "_quotient"}, 32'(get_q(w)), 32'(eq));
        check({tag, "_remainder"}, 32'(get_r(w)), 32'(er));
        check({tag, "_flags"}, 32'(get_f(w)), 32'(ef));
        step();
        check({tag, "_done_width"}, 32'(get_done(w)), 32'd0);
        check({tag, "_busy_after"}, 32'(get_busy(w)), 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        int ndone, lat, dlat;
        logic [7:0] dq, dr;

        rst_n  = 1'b0;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        step();
        step();
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_quotient", 32'(q8), 32'd0);
        check("rst_remainder", 32'(r8), 32'd0);
        check("rst_flags", 32'(f8), 32'd0);
        check("rst_quotient4", 32'(q4), 32'd0);
        rst_n = 1'b1;
        step();

        // Directed cases.
        run_div(8, 8'd250, 8'd56, "d250_56");
        run_div(4, 8'd10, 8'd6, "w4_10_6");
        run_div(4, 8'd15, 8'd15, "w4_15_15");
        run_div(4, 8'd3, 8'd6, "w4_3_6");
        run_div(8, 8'd200, 8'd0, "dbz200");
        run_div(8, 8'd0, 8'd37, "zero_dividend");
        run_div(8, 8'd255, 8'd255, "max_max");
        run_div(4, 8'd9, 8'd0, "w4_dbz");

        // Second start during RUN is ignored.
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
        step();
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        step();
        step();
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
        lat = 2;
        step();
        lat++;
        start8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
        ndone = 0; dlat = -1; dq = 8'd0; dr = 8'd0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                ndone++;
                if (dlat < 0) begin
                    dlat = lat;
                    dq = q8;
                    dr = r8;
                end
            end
            step();
            lat++;
        end
        check("restart_done_count", 32'(ndone), 32'd1);
        check("restart_latency", 32'(dlat), 32'd8);
        check("restart_quotient", 32'(dq), 32'd14);
        check("restart_remainder", 32'(dr), 32'd2);
        check("restart_idle_busy", 32'(busy8), 32'd0);

        // Asynchronous reset mid-operation.
        start8 = 1'b1; a8 = 8'd255; b8 = 8'd1;
        step();
        start8 = 1'b0;
        step();
        step();
        step();
        check("pre_reset_busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_done", 32'(done8), 32'd0);
        check("midrst_quotient", 32'(q8), 32'd0);
        check("midrst_remainder", 32'(r8), 32'd0);
        check("midrst_flags", 32'(f8), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8 || busy8) ndone++;
            step();
        end
        check("postrst_quiet", 32'(ndone), 32'd0);
        run_div(8, 8'd255, 8'd1, "after_rst");

        // Back-to-back: start in DONE is ignored, start in following IDLE taken.
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd9;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done8) break;
            step();
        end
        check("b2b_first_done", 32'(done8), 32'd1);
        start8 = 1'b1; a8 = 8'd50; b8 = 8'd5;
        step();
        check("b2b_ignored_busy", 32'(busy8), 32'd0);
        check("b2b_ignored_done", 32'(done8), 32'd0);
        check("b2b_hold_quotient", 32'(q8), 32'd22);
        check("b2b_hold_remainder", 32'(r8), 32'd2);
        run_div(8, 8'd77, 8'd4, "b2b_second");

        // Random operands against the arithmetic model.
        for (int k = 0; k < 30; k++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 8'd0;
                1:       rb = (ra == 8'hFF) ? 8'hFF : 8'($urandom_range(32'(ra) + 1, 255));
                2:       rb = 8'd1;
                default: rb = 8'($urandom_range(1, 255));
            endcase
            run_div(8, ra, rb, "rnd8");
        end
        for (int k = 0; k < 15; k++) begin
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 15));
            run_div(4, ra, rb, "rnd4");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
